// File: rtl/lock_ctrl_if.sv
// Keypad-event / lock-status bundle between the scanner, lock_ctrl and the actuator drivers.
interface lock_ctrl_if;
   logic       key_flag;
   logic [3:0] key_value;
   logic       unlock;
   logic       alarm;
   logic       ok_pulse;
   logic       err_pulse;
   logic [3:0] digit_cnt;
   logic [2:0] fail_cnt;

   modport master (
      output key_flag, key_value,
      input  unlock, alarm, ok_pulse, err_pulse, digit_cnt, fail_cnt
   );

   modport slave (
      input  key_flag, key_value,
      output unlock, alarm, ok_pulse, err_pulse, digit_cnt, fail_cnt
   );
endinterface

// File: rtl/lock_ctrl.sv
// Password-lock controller: digit entry, compare, timed unlock, failure counting, alarm lockout.
// Optional CHANGE_PWD_EN macro adds a SET state for changing the password while open.
module lock_ctrl #(
   parameter int unsigned PWD_LEN     = 4,
   parameter logic [31:0] PWD_DEFAULT = 32'h0000_1234,
   parameter int unsigned MAX_FAIL    = 3,
   parameter int unsigned UNLOCK_CYC  = 250_000_000,
   parameter int unsigned LOCK_CYC    = 500_000_000
) (
   input logic        clk,
   input logic        rst_n,
   lock_ctrl_if.slave bus
);
   localparam int unsigned BUF_W = 32;
   localparam int unsigned TMR_W = 32;

   localparam logic [BUF_W-1:0] PWD_MASK   = BUF_W'((64'd1 << (4 * PWD_LEN)) - 64'd1);
   localparam logic [3:0]       LEN_C      = 4'(PWD_LEN);
   localparam logic [2:0]       MAX_C      = 3'(MAX_FAIL);
   localparam logic [TMR_W-1:0] UNLOCK_END = TMR_W'(UNLOCK_CYC - 1);
   localparam logic [TMR_W-1:0] LOCK_END   = TMR_W'(LOCK_CYC - 1);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_ENTRY   = 3'd1;
   localparam logic [2:0] ST_OPEN    = 3'd2;
   localparam logic [2:0] ST_LOCKOUT = 3'd3;
`ifdef CHANGE_PWD_EN
   localparam logic [2:0] ST_SET     = 3'd4;
`endif

   logic [2:0]       state_q, state_d;
   logic [BUF_W-1:0] buf_q, buf_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [2:0]       fail_q, fail_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic             unlock_q, unlock_d;
   logic             alarm_q, alarm_d;
   logic             ok_q, ok_d;
   logic             err_q, err_d;
   logic [BUF_W-1:0] pwd_cur;

   logic is_digit, is_star, is_hash, timing;

`ifdef CHANGE_PWD_EN
   logic [BUF_W-1:0] pwd_q, pwd_d;
   assign pwd_cur = pwd_q;
`else
   assign pwd_cur = PWD_DEFAULT & PWD_MASK;
`endif

   assign is_digit = bus.key_flag && (bus.key_value <= 4'd9);
   assign is_star  = bus.key_flag && (bus.key_value == 4'd10);
   assign is_hash  = bus.key_flag && (bus.key_value == 4'd11);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         buf_q    <= '0;
         cnt_q    <= '0;
         fail_q   <= '0;
         timer_q  <= '0;
         unlock_q <= 1'b0;
         alarm_q  <= 1'b0;
         ok_q     <= 1'b0;
         err_q    <= 1'b0;
`ifdef CHANGE_PWD_EN
         pwd_q    <= PWD_DEFAULT & PWD_MASK;
`endif
      end else begin
         state_q  <= state_d;
         buf_q    <= buf_d;
         cnt_q    <= cnt_d;
         fail_q   <= fail_d;
         timer_q  <= timer_d;
         unlock_q <= unlock_d;
         alarm_q  <= alarm_d;
         ok_q     <= ok_d;
         err_q    <= err_d;
`ifdef CHANGE_PWD_EN
         pwd_q    <= pwd_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      buf_d   = buf_q;
      cnt_d   = cnt_q;
      fail_d  = fail_q;
      ok_d    = 1'b0;
      err_d   = 1'b0;
`ifdef CHANGE_PWD_EN
      pwd_d   = pwd_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (is_digit) begin
               buf_d   = {buf_q[BUF_W-5:0], bus.key_value};
               cnt_d   = 4'd1;
               state_d = ST_ENTRY;
            end
         end
         ST_ENTRY: begin
            if (is_digit && (cnt_q < LEN_C)) begin
               buf_d = {buf_q[BUF_W-5:0], bus.key_value};
               cnt_d = cnt_q + 4'd1;
            end else if (is_star) begin
               buf_d   = '0;
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else if (is_hash) begin
               buf_d = '0;
               cnt_d = '0;
               if ((cnt_q == LEN_C) && ((buf_q & PWD_MASK) == pwd_cur)) begin
                  ok_d    = 1'b1;
                  fail_d  = '0;
                  state_d = ST_OPEN;
               end else begin
                  err_d   = 1'b1;
                  fail_d  = fail_q + 3'd1;
                  state_d = (fail_d == MAX_C) ? ST_LOCKOUT : ST_IDLE;
               end
            end
         end
         ST_OPEN: begin
            if (is_star || (timer_q == UNLOCK_END)) begin
               state_d = ST_IDLE;
`ifdef CHANGE_PWD_EN
            end else if (is_hash) begin
               buf_d   = '0;
               cnt_d   = '0;
               state_d = ST_SET;
`endif
            end
         end
         ST_LOCKOUT: begin
            if (timer_q == LOCK_END) begin
               fail_d  = '0;
               state_d = ST_IDLE;
            end
         end
`ifdef CHANGE_PWD_EN
         ST_SET: begin
            if (is_star || (timer_q == UNLOCK_END)) begin
               buf_d   = '0;
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else if (is_hash) begin
               if (cnt_q == LEN_C) begin
                  pwd_d = buf_q & PWD_MASK;
                  ok_d  = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
               buf_d   = '0;
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else if (is_digit && (cnt_q < LEN_C)) begin
               buf_d = {buf_q[BUF_W-5:0], bus.key_value};
               cnt_d = cnt_q + 4'd1;
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase

      // Timer restarts on every state change and only runs in the timed states.
      timing = (state_q == ST_OPEN) || (state_q == ST_LOCKOUT);
`ifdef CHANGE_PWD_EN
      timing = timing || (state_q == ST_SET);
`endif
      timer_d  = ((state_d == state_q) && timing) ? timer_q + TMR_W'(1) : '0;

      unlock_d = (state_d == ST_OPEN);
`ifdef CHANGE_PWD_EN
      unlock_d = unlock_d || (state_d == ST_SET);
`endif
      alarm_d  = (state_d == ST_LOCKOUT);
   end

   assign bus.unlock    = unlock_q;
   assign bus.alarm     = alarm_q;
   assign bus.ok_pulse  = ok_q;
   assign bus.err_pulse = err_q;
   assign bus.digit_cnt = cnt_q;
   assign bus.fail_cnt  = fail_q;
endmodule

// File: tb/tb_lock_ctrl.sv
// Scoreboard bench for lock_ctrl: directed key sequences, pulse responses checked by a monitor.
module tb_lock_ctrl;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   lock_ctrl_if bus();

   lock_ctrl #(
      .UNLOCK_CYC(20),
      .LOCK_CYC  (40)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   typedef struct packed {
      logic       ok;
      logic       unlock;
      logic       alarm;
      logic [2:0] fail;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every pulse must match the oldest expected response.
   always @(negedge clk) begin
      if (rst_n && (bus.ok_pulse || bus.err_pulse)) begin
         tests++;
         if (sb.size() == 0) begin
            fails++;
            $display("FAIL unexpected_pulse: ok=%0b err=%0b with nothing expected",
                     bus.ok_pulse, bus.err_pulse);
         end else begin
            exp_t e;
            logic [6:0] act, req;
            e   = sb.pop_front();
            act = {bus.ok_pulse, bus.err_pulse, bus.unlock, bus.alarm, bus.fail_cnt};
            req = {e.ok, ~e.ok, e.unlock, e.alarm, e.fail};
            if (act !== req) begin
               fails++;
               $display("FAIL response {ok,err,unlock,alarm,fail}: got %b expected %b", act, req);
            end
         end
      end
   end

   task automatic press(input int k);
      @(negedge clk);
      bus.key_flag  = 1'b1;
      bus.key_value = 4'(k);
      @(negedge clk);
      bus.key_flag  = 1'b0;
      bus.key_value = 4'($urandom_range(0, 15));
   endtask

   task automatic expect_resp(input logic ok, input logic unl, input logic alm, input int f);
      sb.push_back('{ok: ok, unlock: unl, alarm: alm, fail: 3'(f)});
   endtask

   task automatic enter4(input int a, input int b, input int c, input int d);
      press(a); press(b); press(c); press(d);
   endtask

   task automatic check_zero(input string name);
      check(name, 32'({bus.unlock, bus.alarm, bus.ok_pulse, bus.err_pulse, bus.digit_cnt, bus.fail_cnt}), 32'd0);
   endtask

   task automatic do_reset(input string name);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_zero(name);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst_n         = 1'b0;
      bus.key_flag  = 1'b0;
      bus.key_value = 4'd0;
      repeat (3) @(negedge clk);
      check_zero("reset_state");
      rst_n = 1'b1;

      // Correct code, unlock duration
      press(1); press(2); press(3);
      check("digit_cnt_3", 32'(bus.digit_cnt), 32'd3);
      press(4);
      expect_resp(1'b1, 1'b1, 1'b0, 0);
      press(11);
      n = 0;
      while (bus.unlock && n < 100) begin n++; @(negedge clk); end
      check("unlock_len", 32'(n), 32'd20);
      check("digit_cnt_after_hash", 32'(bus.digit_cnt), 32'd0);

      // Wrong code, then short code
      enter4(1, 2, 3, 5);
      expect_resp(1'b0, 1'b0, 1'b0, 1);
      press(11);
      press(1); press(2);
      expect_resp(1'b0, 1'b0, 1'b0, 2);
      press(11);
      check("unlock_after_wrong", 32'(bus.unlock), 32'd0);

      // Lockout
      do_reset("reset_before_lockout");
      for (int i = 1; i <= 3; i++) begin
         enter4(9, 9, 9, 9);
         expect_resp(1'b0, 1'b0, (i == 3), i);
         press(11);
      end
      enter4(1, 2, 3, 4);
      press(11);
      check("alarm_held", 32'(bus.alarm), 32'd1);
      n = 10;
      while (bus.alarm && n < 200) begin n++; @(negedge clk); end
      check("alarm_len", 32'(n), 32'd40);
      check("fail_cleared", 32'(bus.fail_cnt), 32'd0);
      enter4(1, 2, 3, 4);
      expect_resp(1'b1, 1'b1, 1'b0, 0);
      press(11);
      press(10);
      check("relock_star", 32'(bus.unlock), 32'd0);

      // Clear, unused codes, saturation
      press(9); press(9);
      check("cnt_before_clear", 32'(bus.digit_cnt), 32'd2);
      press(10);
      check("cnt_after_clear", 32'(bus.digit_cnt), 32'd0);
      press(12);
      check("unused_idle", 32'(bus.digit_cnt), 32'd0);
      enter4(1, 2, 3, 4);
      press(5);
      check("cnt_saturate", 32'(bus.digit_cnt), 32'd4);
      press(15);
      check("unused_entry", 32'(bus.digit_cnt), 32'd4);
      expect_resp(1'b1, 1'b1, 1'b0, 0);
      press(11);
      press(5);
      check("digit_in_open", 32'(bus.unlock), 32'd1);
      press(10);
      check("star_in_open", 32'(bus.unlock), 32'd0);

      // Reset mid-ENTRY and mid-OPEN
      press(1); press(2); press(3);
      check("cnt_mid_entry", 32'(bus.digit_cnt), 32'd3);
      do_reset("reset_mid_entry");
      enter4(1, 2, 3, 4);
      expect_resp(1'b1, 1'b1, 1'b0, 0);
      press(11);
      do_reset("reset_mid_open");
      enter4(1, 2, 3, 4);
      expect_resp(1'b1, 1'b1, 1'b0, 0);
      press(11);
      press(10);

`ifdef CHANGE_PWD_EN
      // Password change
      enter4(1, 2, 3, 4);
      expect_resp(1'b1, 1'b1, 1'b0, 0);
      press(11);
      press(11);
      check("set_unlock", 32'(bus.unlock), 32'd1);
      enter4(5, 6, 7, 8);
      check("set_cnt", 32'(bus.digit_cnt), 32'd4);
      expect_resp(1'b1, 1'b0, 1'b0, 0);
      press(11);
      check("set_done_unlock", 32'(bus.unlock), 32'd0);
      enter4(1, 2, 3, 4);
      expect_resp(1'b0, 1'b0, 1'b0, 1);
      press(11);
      enter4(5, 6, 7, 8);
      expect_resp(1'b1, 1'b1, 1'b0, 0);
      press(11);
      press(10);
`endif

      repeat (5) @(negedge clk);
      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/lock_ctrl.md
Name: lock_ctrl

Overview:
- Password-lock controller: consumes decoded key events from the 3x4 keypad scanner and sequences entry, compare, unlock timing, failure counting and alarm lockout.
- Sits between the keypad scanner and the actuator/buzzer/LED drivers.
- Keypad codes: 0-9 digit, 10 = '*' (clear/relock), 11 = '#' (enter). Codes 12-15 are ignored.

Parameters:
- PWD_LEN, 4: digits per password (1..8).
- PWD_DEFAULT, 32'h0000_1234: reset password, BCD, low PWD_LEN nibbles used; last-entered digit is the low nibble.
- MAX_FAIL, 3: consecutive wrong attempts that trigger lockout (1..7).
- UNLOCK_CYC, 250_000_000: cycles unlock stays high (5 s at 50 MHz).
- LOCK_CYC, 500_000_000: lockout duration in cycles.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: reset. Asynchronous, active-low.
- key_flag, in, 1: one-cycle key-event strobe.
- key_value, in, 4: key code, valid only when key_flag=1.
- unlock, out, 1: lock actuator enable.
- alarm, out, 1: lockout indicator.
- ok_pulse, out, 1: one-cycle pulse on successful unlock or password change.
- err_pulse, out, 1: one-cycle pulse on a rejected attempt.
- digit_cnt, out, 4: digits currently buffered (0..PWD_LEN).
- fail_cnt, out, 3: consecutive failures.

Behaviour:
- Reset: state IDLE; all outputs 0; buffer 0; timer 0; password register = PWD_DEFAULT.
- All outputs are registered. A key event sampled at edge N takes effect at edge N, so the response is visible in the cycle after the key_flag cycle.
- Key events arriving while key_flag=0 do not exist. key_value is don't-care then.
- ok_pulse/err_pulse are high for exactly 1 cycle.
- States: IDLE, ENTRY, OPEN, LOCKOUT (plus SET with the optional feature).
- IDLE:
  - digit: buffer = {buffer<<4 | digit}, digit_cnt = 1, go to ENTRY.
  - '*' or '#': ignored.
- ENTRY:
  - digit with digit_cnt < PWD_LEN: shift into buffer, digit_cnt+1.
  - digit with digit_cnt == PWD_LEN: ignored (saturates; no overwrite).
  - '*': buffer and digit_cnt cleared, go to IDLE.
  - '#', match (digit_cnt == PWD_LEN and buffer == password): go to OPEN; unlock=1, ok_pulse, fail_cnt=0.
  - '#', mismatch (including a short entry): err_pulse, fail_cnt+1. If the new fail_cnt == MAX_FAIL, go to LOCKOUT with alarm=1; otherwise go to IDLE.
  - Buffer and digit_cnt are cleared on every '#'.
- OPEN:
  - Timer starts at 0 on entry. When timer == UNLOCK_CYC-1, go to IDLE with unlock=0.
  - '*': immediate relock to IDLE.
  - Digits ignored.
- LOCKOUT:
  - All keys ignored.
  - When timer == LOCK_CYC-1, go to IDLE with alarm=0 and fail_cnt=0.
- Timer: 32-bit, cleared on every state change, increments only in OPEN, LOCKOUT and SET.
- Reset mid-operation (any state) returns to the reset values. With CHANGE_PWD_EN, the password register also reverts to PWD_DEFAULT.
- Unused key codes (12-15) have no effect in any state.

Optional Feature:
- Macro: CHANGE_PWD_EN.
- Enabled:
  - '#' in OPEN goes to SET; unlock stays 1, timer restarts.
  - SET buffers digits as in ENTRY.
  - '#' with digit_cnt == PWD_LEN: password = buffer, ok_pulse, go to IDLE (unlock=0).
  - '#' with a short entry: err_pulse, password unchanged, go to IDLE. fail_cnt is not affected.
  - '*' or timer == UNLOCK_CYC-1: abort to IDLE, password unchanged.
- Disabled: '#' in OPEN is ignored; the password is the constant PWD_DEFAULT; the SET state does not exist.

Test Plan:
All tests use UNLOCK_CYC=20, LOCK_CYC=40, defaults otherwise.
- Correct code: keys 1,2,3,4,'#' -> unlock=1 and ok_pulse one cycle after the '#' strobe; unlock stays high exactly 20 cycles; fail_cnt=0.
- Wrong/short code: keys 1,2,3,5,'#' -> err_pulse, fail_cnt=1, unlock=0. Then keys 1,2,'#' -> fail_cnt=2.
- Lockout: three wrong entries -> alarm=1 after the third '#'. Keys 1,2,3,4,'#' during lockout produce no response. alarm=0 and fail_cnt=0 after 40 cycles. Then 1,2,3,4,'#' unlocks.
- Clear/saturation: keys 9,9,'*',1,2,3,4,5,'#' -> digit_cnt saturates at 4 after the '5'; buffer 1234 -> unlock. '*' during OPEN drops unlock on the next cycle.
- Reset: rst_n low mid-ENTRY (digit_cnt=3) and mid-OPEN -> all outputs 0 immediately; a subsequent 1,2,3,4,'#' unlocks.
- CHANGE_PWD_EN: unlock, then '#',5,6,7,8,'#' -> ok_pulse, unlock=0. Then 1,2,3,4,'#' -> err_pulse. Then 5,6,7,8,'#' -> unlock=1.
